// File: rtl/serial_link_arbiter_if.sv
// Requester/link bundle for serial_link_arbiter.
// SERIAL_LINK_ARB_ERR_INJ_EN adds the inj_err_i parity-corruption input.
interface serial_link_arbiter_if #(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 10
);
  localparam int ID_W = $clog2(N_REQ);

  logic [N_REQ-1:0]        req_i;
  logic [N_REQ*DATA_W-1:0] req_data_i;
  logic [N_REQ-1:0]        gnt_o;
  logic                    busy_o;
  logic [ID_W-1:0]         cur_id_o;
  logic                    ser_data_o;
  logic                    ser_data_en_o;
`ifdef SERIAL_LINK_ARB_ERR_INJ_EN
  logic                    inj_err_i;
`endif

  modport master (
`ifdef SERIAL_LINK_ARB_ERR_INJ_EN
    output inj_err_i,
`endif
    output req_i, req_data_i,
    input  gnt_o, busy_o, cur_id_o, ser_data_o, ser_data_en_o
  );

  modport slave (
`ifdef SERIAL_LINK_ARB_ERR_INJ_EN
    input  inj_err_i,
`endif
    input  req_i, req_data_i,
    output gnt_o, busy_o, cur_id_o, ser_data_o, ser_data_en_o
  );
endinterface

// File: rtl/serial_link_arbiter.sv
// Round-robin arbiter framing one granted word per frame onto a serial link.
// SERIAL_LINK_ARB_ERR_INJ_EN enables per-frame parity inversion via inj_err_i.
module serial_link_arbiter #(
  parameter int          N_REQ      = 4,
  parameter int          DATA_W     = 10,
  parameter logic [3:0]  PREAMB     = 4'b1010,
  parameter int          GAP_CYCLES = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  serial_link_arbiter_if.slave  bus
);
  localparam int ID_W    = $clog2(N_REQ);
  localparam int MAX_LEN = (DATA_W > GAP_CYCLES) ? ((DATA_W > 4) ? DATA_W : 4)
                                                 : ((GAP_CYCLES > 4) ? GAP_CYCLES : 4);
  localparam int CNT_W   = $clog2(MAX_LEN) + 1;
  localparam int SH_W    = 3 + DATA_W + 1;

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(4 - 1);
  localparam logic [CNT_W-1:0] CNT_DAT  = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] CNT_GAP  = CNT_W'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PRE  = 3'd1,
    ST_DAT  = 3'd2,
    ST_PAR  = 3'd3,
    ST_GAP  = 3'd4
  } state_e;

  generate
    if (GAP_CYCLES < 2) begin : g_bad_gap
      $error("serial_link_arbiter: GAP_CYCLES must be at least 2");
    end
    if (N_REQ < 2 || N_REQ > 16) begin : g_bad_nreq
      $error("serial_link_arbiter: N_REQ must be in 2..16");
    end
  endgenerate

  function automatic logic even_parity(input logic [DATA_W-1:0] d);
    return ^d;
  endfunction

  // Rotate so bit 0 is ptr+1, find the lowest set bit, map back to an index.
  function automatic logic [ID_W:0] rr_pick(input logic [N_REQ-1:0] req,
                                            input logic [ID_W-1:0]  ptr);
    logic [N_REQ-1:0] rot;
    logic [ID_W:0]    off;
    logic [ID_W:0]    sum;
    rot = N_REQ'({req, req} >> ({1'b0, ptr} + (ID_W+1)'(1)));
    off = {(ID_W+1){1'b0}};
    for (int i = N_REQ - 1; i >= 0; i--) begin
      off = rot[i] ? (ID_W+1)'(i) : off;
    end
    sum = {1'b0, ptr} + (ID_W+1)'(1) + off;
    sum = (sum >= (ID_W+1)'(N_REQ)) ? (sum - (ID_W+1)'(N_REQ)) : sum;
    return {|req, sum[ID_W-1:0]};
  endfunction

  state_e            state_r, state_nxt_s;
  logic [CNT_W-1:0]  cnt_r, cnt_nxt_s;
  logic [ID_W-1:0]   ptr_r, cur_id_r;
  logic [SH_W-1:0]   sh_r;
  logic              ser_data_r, ser_en_r;
  logic [ID_W:0]     pick_s;
  logic              pick_vld_s;
  logic [ID_W-1:0]   pick_id_s;
  logic [DATA_W-1:0] slice_s;
  logic              par_s;
  logic [N_REQ-1:0]  gnt_s;
  logic              busy_s, ser_bit_s, ser_en_s, load_s, shift_s;

  assign pick_s     = rr_pick(bus.req_i, ptr_r);
  assign pick_vld_s = pick_s[ID_W] & ~rst_i;
  assign pick_id_s  = pick_s[ID_W-1:0];

  // Select the payload slice of the winning requester.
  always_comb begin
    slice_s = {DATA_W{1'b0}};
    for (int k = 0; k < N_REQ; k++) begin
      slice_s = (pick_id_s == ID_W'(k)) ? bus.req_data_i[k*DATA_W +: DATA_W] : slice_s;
    end
  end

`ifdef SERIAL_LINK_ARB_ERR_INJ_EN
  assign par_s = even_parity(slice_s) ^ bus.inj_err_i;
`else
  assign par_s = even_parity(slice_s);
`endif

  // FSM state and phase counter.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r <= ST_IDLE;
      cnt_r   <= CNT_ZERO;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  // Next-state: each phase reloads the counter and leaves when it hits zero.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    case (state_r)
      ST_IDLE: begin
        if (pick_vld_s) begin
          state_nxt_s = ST_PRE;
          cnt_nxt_s   = CNT_PRE;
        end else begin
          state_nxt_s = ST_IDLE;
          cnt_nxt_s   = cnt_r;
        end
      end
      ST_PRE: begin
        if (cnt_r == CNT_ZERO) begin
          state_nxt_s = ST_DAT;
          cnt_nxt_s   = CNT_DAT;
        end else begin
          cnt_nxt_s   = cnt_r - CNT_ONE;
        end
      end
      ST_DAT: begin
        if (cnt_r == CNT_ZERO) begin
          state_nxt_s = ST_PAR;
          cnt_nxt_s   = CNT_ZERO;
        end else begin
          cnt_nxt_s   = cnt_r - CNT_ONE;
        end
      end
      ST_PAR: begin
        state_nxt_s = ST_GAP;
        cnt_nxt_s   = CNT_GAP;
      end
      ST_GAP: begin
        if (cnt_r == CNT_ZERO) begin
          state_nxt_s = ST_IDLE;
          cnt_nxt_s   = CNT_ZERO;
        end else begin
          cnt_nxt_s   = cnt_r - CNT_ONE;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        cnt_nxt_s   = CNT_ZERO;
      end
    endcase
  end

  // Outputs: the serial bit computed here is shown one cycle later.
  always_comb begin
    gnt_s     = {N_REQ{1'b0}};
    busy_s    = 1'b0;
    ser_bit_s = 1'b0;
    ser_en_s  = 1'b0;
    load_s    = 1'b0;
    shift_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (pick_vld_s) begin
          gnt_s     = {{(N_REQ-1){1'b0}}, 1'b1} << pick_id_s;
          busy_s    = 1'b1;
          load_s    = 1'b1;
          ser_bit_s = PREAMB[3];
          ser_en_s  = 1'b1;
        end else begin
          gnt_s     = {N_REQ{1'b0}};
          busy_s    = 1'b0;
        end
      end
      ST_PRE, ST_DAT: begin
        busy_s    = 1'b1;
        shift_s   = 1'b1;
        ser_bit_s = sh_r[SH_W-1];
        ser_en_s  = 1'b1;
      end
      ST_PAR, ST_GAP: begin
        busy_s    = 1'b1;
      end
      default: begin
        busy_s    = 1'b0;
      end
    endcase
  end

  // Frame shift register, round-robin pointer and registered link outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ptr_r      <= ID_W'(N_REQ - 1);
      cur_id_r   <= {ID_W{1'b0}};
      sh_r       <= {SH_W{1'b0}};
      ser_data_r <= 1'b0;
      ser_en_r   <= 1'b0;
    end else begin
      if (load_s) begin
        ptr_r    <= pick_id_s;
        cur_id_r <= pick_id_s;
        sh_r     <= {PREAMB[2:0], slice_s, par_s};
      end else if (shift_s) begin
        sh_r     <= {sh_r[SH_W-2:0], 1'b0};
      end else begin
        sh_r     <= sh_r;
      end
      ser_data_r <= ser_bit_s;
      ser_en_r   <= ser_en_s;
    end
  end

  assign bus.gnt_o         = gnt_s;
  assign bus.busy_o        = busy_s;
  assign bus.cur_id_o      = cur_id_r;
  assign bus.ser_data_o    = ser_data_r;
  assign bus.ser_data_en_o = ser_en_r;
endmodule

// File: tb/tb_serial_link_arbiter.sv
// Self-checking bench for serial_link_arbiter: vector table, multi-frame and reset/gap corner sequences.
// Frames are checked against a queue of expected words filled when stimulus is driven.
module tb_serial_link_arbiter;
  localparam int N_REQ   = 4;
  localparam int DATA_W  = 10;
  localparam int FRAME_W = 4 + DATA_W + 1;
  localparam int SPACING = 1 + 15 + 2;

  logic clk;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  logic [FRAME_W-1:0] exp_q[$];

  serial_link_arbiter_if #(.N_REQ(N_REQ), .DATA_W(DATA_W)) bus ();

  serial_link_arbiter #(
    .N_REQ(N_REQ), .DATA_W(DATA_W), .PREAMB(4'b1010), .GAP_CYCLES(2)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [3:0]        req;
    logic [DATA_W-1:0] data;
    int                exp_id;
    logic              exp_par;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [FRAME_W-1:0] mk_frame(input logic [DATA_W-1:0] d, input logic p);
    return {4'b1010, d, p};
  endfunction

  // Frame monitor: collects serial bits and compares each closed frame with the scoreboard.
  initial begin
    logic [FRAME_W-1:0] acc;
    int nbits;
    acc = '0;
    nbits = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        acc = '0;
        nbits = 0;
      end else begin
        check("busy_covers_en", {31'd0, bus.busy_o | ~bus.ser_data_en_o}, 32'd1);
        check("gnt_onehot0", {31'd0, $onehot0(bus.gnt_o)}, 32'd1);
        if (bus.ser_data_en_o) begin
          acc = {acc[FRAME_W-2:0], bus.ser_data_o};
          nbits++;
        end else if (nbits != 0) begin
          check("frame_len", nbits, FRAME_W);
          check("frame_expected", {31'd0, exp_q.size() != 0}, 32'd1);
          if (exp_q.size() != 0) check("frame_bits", {17'd0, acc}, {17'd0, exp_q.pop_front()});
          nbits = 0;
        end
      end
    end
  end

  task automatic drive_data(input int gid, input logic [DATA_W-1:0] d);
    for (int j = 0; j < N_REQ; j++) bus.req_data_i[j*DATA_W +: DATA_W] = (j == gid) ? d : ~d;
  endtask

  task automatic wait_gnt(input int exp_id, output int gcyc, output int low_busy);
    logic seen;
    seen = 1'b0;
    low_busy = 0;
    gcyc = -1;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      if (bus.gnt_o != 4'b0000) seen = 1'b1;
      else if (!bus.busy_o) low_busy++;
    end
    check("gnt_seen", {31'd0, seen}, 32'd1);
    if (seen) begin
      check("gnt_id", {28'd0, bus.gnt_o}, 32'd1 << exp_id);
      check("busy_at_gnt", {31'd0, bus.busy_o}, 32'd1);
      gcyc = cyc;
    end
  endtask

  // Drops the request after its grant and measures the enable window of the frame.
  task automatic frame_after_gnt(input int exp_id);
    int hi, lo;
    hi = 0;
    lo = 0;
    @(posedge clk); #1;
    bus.req_i = 4'b0000;
`ifdef SERIAL_LINK_ARB_ERR_INJ_EN
    bus.inj_err_i = 1'b0;
`endif
    for (int c = 0; c < 17; c++) begin
      @(negedge clk);
      if (c == 0) check("cur_id", {30'd0, bus.cur_id_o}, exp_id);
      if (c < 15) hi += int'(bus.ser_data_en_o);
      else lo += int'(!bus.ser_data_en_o);
    end
    check("en_high_cycles", hi, 15);
    check("en_low_after", lo, 2);
  endtask

  task automatic wait_idle();
    logic done;
    done = 1'b0;
    for (int i = 0; i < 60 && !done; i++) begin
      @(negedge clk);
      done = !bus.busy_o && (exp_q.size() == 0);
    end
    check("drained_idle", {31'd0, done}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    int g, lb, prev;
    logic [DATA_W-1:0] dk[4];

    vecs[0] = '{4'b0001, 10'h2A5, 0, 1'b1};
    vecs[1] = '{4'b1111, 10'h3FF, 1, 1'b0};
    vecs[2] = '{4'b1001, 10'h000, 3, 1'b0};
    vecs[3] = '{4'b0110, 10'h155, 1, 1'b1};
    vecs[4] = '{4'b0010, 10'h001, 1, 1'b1};
    vecs[5] = '{4'b0001, 10'h200, 0, 1'b1};
    vecs[6] = '{4'b1100, 10'h0F0, 2, 1'b0};
    vecs[7] = '{4'b1000, 10'h3FE, 3, 1'b1};
    dk[0] = 10'h0C3; dk[1] = 10'h35A; dk[2] = 10'h1E7; dk[3] = 10'h204;

    // Reset state, with requests pending during reset.
    rst = 1'b1;
    bus.req_i = 4'b1111;
    bus.req_data_i = '0;
`ifdef SERIAL_LINK_ARB_ERR_INJ_EN
    bus.inj_err_i = 1'b0;
`endif
    repeat (3) @(negedge clk);
    check("rst_gnt", {28'd0, bus.gnt_o}, 32'd0);
    check("rst_busy", {31'd0, bus.busy_o}, 32'd0);
    check("rst_cur_id", {30'd0, bus.cur_id_o}, 32'd0);
    check("rst_ser", {31'd0, bus.ser_data_o}, 32'd0);
    check("rst_en", {31'd0, bus.ser_data_en_o}, 32'd0);
    @(posedge clk); #1;
    bus.req_i = 4'b0000;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("idle_busy", {31'd0, bus.busy_o}, 32'd0);

    // Single-frame vectors, each started from IDLE.
    for (int v = 0; v < 8; v++) begin
      @(posedge clk); #1;
      drive_data(vecs[v].exp_id, vecs[v].data);
      bus.req_i = vecs[v].req;
      exp_q.push_back(mk_frame(vecs[v].data, vecs[v].exp_par));
      wait_gnt(vecs[v].exp_id, g, lb);
      frame_after_gnt(vecs[v].exp_id);
    end
    wait_idle();

    // All requesters held: round-robin order at minimum spacing.
    @(posedge clk); #1;
    for (int j = 0; j < N_REQ; j++) bus.req_data_i[j*DATA_W +: DATA_W] = dk[j];
    bus.req_i = 4'b1111;
    prev = -1;
    for (int f = 0; f < 8; f++) begin
      wait_gnt(f % N_REQ, g, lb);
      exp_q.push_back(mk_frame(dk[f % N_REQ], ^dk[f % N_REQ]));
      if (f > 0) check("rr_spacing", g - prev, SPACING);
      prev = g;
    end
    @(posedge clk); #1;
    bus.req_i = 4'b0000;
    wait_idle();

    // Single requester held: back-to-back, busy never drops.
    @(posedge clk); #1;
    bus.req_i = 4'b0100;
    prev = -1;
    for (int f = 0; f < 5; f++) begin
      wait_gnt(2, g, lb);
      exp_q.push_back(mk_frame(dk[2], ^dk[2]));
      if (f > 0) begin
        check("solo_spacing", g - prev, SPACING);
        check("solo_busy_gap", {31'd0, lb <= 1}, 32'd1);
      end
      prev = g;
      @(posedge clk); #1;
      if (f == 4) bus.req_i = 4'b0000;
      @(negedge clk);
      check("solo_cur_id", {30'd0, bus.cur_id_o}, 32'd2);
    end
    wait_idle();

    // Reset in the 7th DAT cycle aborts the frame immediately.
    @(posedge clk); #1;
    drive_data(0, 10'h2C9);
    bus.req_i = 4'b0001;
    exp_q.push_back(mk_frame(10'h2C9, ^(10'h2C9)));
    wait_gnt(0, g, lb);
    @(posedge clk); #1;
    bus.req_i = 4'b0000;
    repeat (10) @(posedge clk);
    #1;
    check("pre_rst_en", {31'd0, bus.ser_data_en_o}, 32'd1);
    rst = 1'b1;
    #1;
    check("async_rst_en", {31'd0, bus.ser_data_en_o}, 32'd0);
    check("async_rst_busy", {31'd0, bus.busy_o}, 32'd0);
    check("async_rst_ser", {31'd0, bus.ser_data_o}, 32'd0);
    exp_q.delete();
    @(posedge clk); #1;
    drive_data(3, 10'h3C5);
    bus.req_i = 4'b1000;
    rst = 1'b0;
    exp_q.push_back(mk_frame(10'h3C5, ^(10'h3C5)));
    wait_gnt(3, g, lb);
    frame_after_gnt(3);
    wait_idle();

    // One-cycle request during GAP is forgotten.
    @(posedge clk); #1;
    drive_data(0, 10'h0AA);
    bus.req_i = 4'b0001;
    exp_q.push_back(mk_frame(10'h0AA, ^(10'h0AA)));
    wait_gnt(0, g, lb);
    @(posedge clk); #1;
    bus.req_i = 4'b0000;
    repeat (15) @(posedge clk);
    #1;
    bus.req_i = 4'b0010;
    @(negedge clk);
    check("gap_no_gnt", {28'd0, bus.gnt_o}, 32'd0);
    @(posedge clk); #1;
    bus.req_i = 4'b0000;
    @(negedge clk);
    check("gap2_busy", {31'd0, bus.busy_o}, 32'd1);
    @(negedge clk);
    check("busy_falls", {31'd0, bus.busy_o}, 32'd0);
    lb = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (bus.gnt_o != 4'b0000) lb++;
    end
    check("dropped_req_no_gnt", lb, 0);
    check("dropped_req_no_frame", exp_q.size(), 0);

`ifdef SERIAL_LINK_ARB_ERR_INJ_EN
    // Injected parity error affects only the sampled frame.
    @(posedge clk); #1;
    drive_data(0, 10'h001);
    bus.inj_err_i = 1'b1;
    bus.req_i = 4'b0001;
    exp_q.push_back(mk_frame(10'h001, 1'b0));
    wait_gnt(0, g, lb);
    frame_after_gnt(0);
    @(posedge clk); #1;
    bus.req_i = 4'b0001;
    exp_q.push_back(mk_frame(10'h001, 1'b1));
    wait_gnt(0, g, lb);
    frame_after_gnt(0);
    wait_idle();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
